// File: rtl/memory_stage_if.sv
// Memory-side bus of memory_stage: request strobes, address, write data with
// byte enables, read data and the access-complete response.
interface memory_stage_if #(
  parameter int DATA_W = 16
);
  localparam int BE_W = DATA_W / 8;

  logic [DATA_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_byte_enable;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_resp;

  modport master (
    output mem_address, mem_read, mem_write, mem_wdata, mem_byte_enable,
    input  mem_rdata, mem_resp
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_wdata, mem_byte_enable,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/memory_stage.sv
// Pipeline memory stage: one load/store (optionally through a pointer word) per op,
// result held on a valid/ready output. Define MEMORY_STAGE_INDIRECT_EN for indirect ops.
module memory_stage #(
  parameter int DATA_W = 16,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_ir,
  input  logic [DATA_W-1:0] in_pc,
  input  logic              in_rd,
  input  logic              in_wr,
  input  logic              in_byte,
  input  logic              in_ind,
  input  logic              in_trap,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_mdr,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_ir,
  output logic [DATA_W-1:0] out_pc,
  memory_stage_if.master    mem
);
  localparam int LANE_W = $clog2(BE_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC1 = 2'd1,
`ifdef MEMORY_STAGE_INDIRECT_EN
    S_ACC2 = 2'd2,
`endif
    S_DONE = 2'd3
  } state_t;

  state_t r_state, w_next_state;

  logic [DATA_W-1:0] r_alu, r_ir, r_pc, r_wdata, r_addr, r_mdr;
  logic              r_rd, r_wr, r_byte;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_mdr, r_out_alu, r_out_ir, r_out_pc;

  logic              w_in_ready, w_accept;
  logic              w_mem_read, w_mem_write, w_busy;
  logic              w_ptr_phase, w_byte_access, w_final_resp;
  logic [LANE_W-1:0] w_lane;
  logic [7:0]        w_rd_byte;
  logic [DATA_W-1:0] w_base_addr, w_word_addr;
  logic [BE_W-1:0]   w_be_lane;

`ifdef MEMORY_STAGE_INDIRECT_EN
  logic r_ind;
`else
  logic w_unused_ind;
  assign w_unused_ind = in_ind;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: defaults first so no branch of the case can leave a signal unassigned (no latches).
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_ptr_phase  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = !r_out_valid || out_ready;
        if (in_valid && w_in_ready) w_next_state = (in_rd || in_wr) ? S_ACC1 : S_DONE;
      end
      S_ACC1: begin
`ifdef MEMORY_STAGE_INDIRECT_EN
        if (r_ind) begin
          // Pointer fetch is always a word read, whatever the op itself does.
          w_ptr_phase = 1'b1;
          w_mem_read  = 1'b1;
          if (mem.mem_resp) w_next_state = S_ACC2;
        end else begin
          w_mem_read  = r_rd;
          w_mem_write = r_wr;
          if (mem.mem_resp) w_next_state = S_DONE;
        end
`else
        w_mem_read  = r_rd;
        w_mem_write = r_wr;
        if (mem.mem_resp) w_next_state = S_DONE;
`endif
      end
`ifdef MEMORY_STAGE_INDIRECT_EN
      S_ACC2: begin
        w_mem_read  = r_rd;
        w_mem_write = r_wr;
        if (mem.mem_resp) w_next_state = S_DONE;
      end
`endif
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_accept      = in_valid && w_in_ready;
  assign w_busy        = w_mem_read || w_mem_write;
  assign w_final_resp  = mem.mem_resp && w_busy && !w_ptr_phase;
  assign w_byte_access = r_byte && !w_ptr_phase;
  assign w_lane        = r_addr[LANE_W-1:0];
  assign w_be_lane     = BE_W'(1) << w_lane;
  assign w_word_addr   = r_addr & ~DATA_W'(BE_W - 1);
  assign w_rd_byte     = 8'(mem.mem_rdata >> {w_lane, 3'b000});
  assign w_base_addr   = in_trap ? DATA_W'({in_ir[7:0], 1'b0}) : in_alu;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_alu       <= '0;
      r_ir        <= '0;
      r_pc        <= '0;
      r_wdata     <= '0;
      r_addr      <= '0;
      r_mdr       <= '0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_byte      <= 1'b0;
`ifdef MEMORY_STAGE_INDIRECT_EN
      r_ind       <= 1'b0;
`endif
      r_out_valid <= 1'b0;
      r_out_mdr   <= '0;
      r_out_alu   <= '0;
      r_out_ir    <= '0;
      r_out_pc    <= '0;
    end else begin
      if (w_accept) begin
        r_alu   <= in_alu;
        r_ir    <= in_ir;
        r_pc    <= in_pc;
        r_wdata <= in_wdata;
        r_addr  <= w_base_addr;
        r_mdr   <= in_alu;
        r_rd    <= in_rd;
        r_wr    <= in_wr;
        r_byte  <= in_byte;
`ifdef MEMORY_STAGE_INDIRECT_EN
        r_ind   <= in_ind;
`endif
      end
`ifdef MEMORY_STAGE_INDIRECT_EN
      if (w_ptr_phase && mem.mem_resp) r_addr <= mem.mem_rdata;
`endif
      if (w_final_resp && r_rd) r_mdr <= w_byte_access ? DATA_W'(w_rd_byte) : mem.mem_rdata;

      // A landing result wins over a drain in the same cycle.
      if (r_state == S_DONE) begin
        r_out_valid <= 1'b1;
        r_out_mdr   <= r_mdr;
        r_out_alu   <= r_alu;
        r_out_ir    <= r_ir;
        r_out_pc    <= r_pc;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_mdr   = r_out_mdr;
  assign out_alu   = r_out_alu;
  assign out_ir    = r_out_ir;
  assign out_pc    = r_out_pc;

  assign mem.mem_read        = w_mem_read;
  assign mem.mem_write       = w_mem_write;
  assign mem.mem_address     = !w_busy ? '0 : (w_byte_access ? r_addr : w_word_addr);
  assign mem.mem_byte_enable = !w_busy ? '0 : (w_byte_access ? w_be_lane : '1);
  assign mem.mem_wdata       = !w_busy ? '0 : (w_byte_access ? {BE_W{r_wdata[7:0]}} : r_wdata);
endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter DATA_W, default 16: data and address width in bits; SHALL be 16 or 32.
REQ-002 Parameter BE_W, default DATA_W/8: byte-enable width; SHALL NOT be overridden.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  in  1  upstream op valid.
REQ-006 in_ready  out  1  stage accepts op this cycle.
REQ-007 in_alu, in_ir, in_pc  in  DATA_W each  ALU result, instruction, PC.
REQ-008 in_rd, in_wr, in_byte, in_ind, in_trap  in  1 each  load, store, byte access, indirect, trap-vector address.
REQ-009 in_wdata  in  DATA_W  store data.
REQ-010 mem_address  out  DATA_W  memory address.
REQ-011 mem_read, mem_write  out  1 each  memory request strobes.
REQ-012 mem_wdata  out  DATA_W; mem_byte_enable  out  BE_W.
REQ-013 mem_rdata  in  DATA_W; mem_resp  in  1  access complete.
REQ-014 out_valid  out  1; out_ready  in  1  downstream handshake.
REQ-015 out_mdr, out_alu, out_ir, out_pc  out  DATA_W each  results to writeback.

Function
REQ-016 in_ready SHALL be 1 only in IDLE and only when out_valid=0 or out_ready=1; an op is accepted when in_valid and in_ready are both 1.
REQ-017 Accepted op fields SHALL be registered; base address = in_trap ? zext(in_ir[7:0])<<1 : in_alu.
REQ-018 FSM states: IDLE, ACC1, ACC2, DONE. IDLE->ACC1 on accept with in_rd|in_wr; IDLE->DONE on accept with neither.
REQ-019 In ACC1/ACC2, mem_read or mem_write SHALL be held high with a stable address until the cycle mem_resp=1; mem_resp outside ACC1/ACC2 SHALL be ignored.
REQ-020 ACC1 with in_ind: read word at base address; on mem_resp capture mem_rdata as the new address, go to ACC2, then perform the op's read or write there.
REQ-021 ACC1 without in_ind (or ACC2): on mem_resp go to DONE.
REQ-022 Word access: address low log2(BE_W) bits forced to 0; mem_byte_enable all ones.
REQ-023 Byte access: byte lane k = address[log2(BE_W)-1:0]; mem_byte_enable one-hot at k; mem_wdata = store byte replicated into every lane.
REQ-024 Byte load: out_mdr = zext(lane k of mem_rdata); word load: out_mdr = mem_rdata; no load: out_mdr = registered in_alu.
REQ-025 DONE SHALL set out_valid=1 with outputs registered and return to IDLE in the same cycle; minimum latency 1 cycle (non-memory op), 1 + memory wait per access otherwise.
REQ-026 out_valid SHALL clear on the cycle out_valid & out_ready unless a new result lands in the same cycle; outputs SHALL stay stable while out_valid=1 and out_ready=0.
REQ-027 Simultaneous drain and accept: SHALL be permitted; no bubble is inserted.
REQ-028 out_alu, out_ir, out_pc SHALL pass the registered inputs unchanged.

Reset
REQ-029 reset_n=0 SHALL force IDLE, out_valid=0, mem_read=0, mem_write=0 and all data outputs to 0, including mid-access; any in-flight op is discarded.

Configuration
REQ-030 MEMORY_STAGE_INDIRECT_EN defined: ACC2 and indirect sequencing per REQ-020.
REQ-031 MEMORY_STAGE_INDIRECT_EN undefined: in_ind ignored, ACC2 absent, every memory op is a single access.

Verification
REQ-032 DATA_W=16, word load at in_alu=0x3001, mem_resp after 3 cycles, rdata=0xBEEF -> mem_address=0x3000, BE=11, out_mdr=0xBEEF, out_valid 4 cycles after accept.
REQ-033 Byte store 0x12AB to 0x2005 -> mem_wdata=0xABAB, BE=10; byte load there with rdata=0x5A77 -> out_mdr=0x005A.
REQ-034 Indirect load (INDIRECT_EN): base 0x0100, first rdata=0x4000, second rdata=0x1234 -> second mem_address=0x4000, out_mdr=0x1234.
REQ-035 Trap in_ir[7:0]=0x25, load -> mem_address=0x004A; out_ready held 0 for 5 cycles -> outputs stable, in_ready=0.
REQ-036 reset_n low during ACC1 with mem_read=1 -> mem_read=0 immediately, out_valid=0; late mem_resp after release ignored.
